// File: rtl/servo_seq_multi.sv
// servo_seq_multi: multi-channel hobby-servo PWM driver fed by a command table
// held in an external synchronous RAM. Each table entry {last, ch, dwell, pos}
// sets one channel's position and then holds for dwell milliseconds. All channels
// share one frame counter. New positions are staged in a shadow register and are
// copied to the active set only at a frame boundary, so a pulse never changes
// width partway through a frame.
//
// Build option: define SERVO_LOOP_EN to make the walk wrap back to address 0
// after the last entry instead of halting in DONE. Only stop then ends the walk.
module servo_seq_multi #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int FRAME_HZ      = 50,
    parameter int NUM_CHANNELS  = 4,
    parameter int POS_LEN       = 8,
    parameter int DWELL_LEN     = 5,
    parameter int ADDR_LEN      = 8,
    parameter int MIN_PULSE_US  = 1000,
    parameter int MAX_PULSE_US  = 2000,
    localparam int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int DATA_LEN     = 1 + CH_BITS + DWELL_LEN + POS_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [DATA_LEN-1:0]     data,
    output logic [ADDR_LEN-1:0]     address,
    output logic [NUM_CHANNELS-1:0] servo_q,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_start
);

    localparam int     FRAME_CYC = CLK_FREQUENCY / FRAME_HZ;
    localparam int     FR_W      = $clog2(FRAME_CYC);
    localparam longint MIN_CYC   = longint'(CLK_FREQUENCY) * MIN_PULSE_US / 1000000;
    localparam longint STEP_CYC  = longint'(MAX_PULSE_US - MIN_PULSE_US) * CLK_FREQUENCY
                                   / 1000000 / (longint'(1) << POS_LEN);
    localparam int     MS_CYC    = CLK_FREQUENCY / 1000;
    localparam int     DW_W      = $clog2(((2 ** DWELL_LEN) - 1) * MS_CYC + 1);

    localparam logic [FR_W-1:0]    FRAME_LAST = FR_W'(FRAME_CYC - 1);
    localparam logic [DW_W-1:0]    MS_CYC_W   = DW_W'(MS_CYC);
    localparam logic [POS_LEN-1:0] CENTRE     = {1'b1, {(POS_LEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_APPLY,
        S_DWELL,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [ADDR_LEN-1:0]       r_address;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_last;
    logic [DW_W-1:0]           r_dwell_ctr;
    logic [FR_W-1:0]           r_frame_ctr;
    logic                      r_frame_start;
    logic [NUM_CHANNELS-1:0]   r_servo_q;
    logic [POS_LEN-1:0]        r_shadow [NUM_CHANNELS];
    logic [POS_LEN-1:0]        r_active [NUM_CHANNELS];

    // Table entry fields, MSB first: {last, ch, dwell, pos}
    logic                      w_last;
    logic [CH_BITS-1:0]        w_ch;
    logic [DWELL_LEN-1:0]      w_dwell;
    logic [POS_LEN-1:0]        w_pos;
    logic                      w_frame_end;
    logic                      w_apply;
    logic [NUM_CHANNELS-1:0]   w_wr;
    logic [NUM_CHANNELS-1:0]   w_pwm;

    assign w_pos       = data[POS_LEN-1:0];
    assign w_dwell     = data[POS_LEN +: DWELL_LEN];
    assign w_ch        = data[POS_LEN + DWELL_LEN +: CH_BITS];
    assign w_last      = data[DATA_LEN-1];
    assign w_frame_end = (r_frame_ctr == FRAME_LAST);
    // stop takes priority over an APPLY in the same cycle, so no write then
    assign w_apply     = (r_state == S_APPLY) && !stop;

    // Per-channel shadow write strobe and PWM compare at full 32-bit width.
    // Out-of-range channel numbers never match any gi, so they write nothing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [31:0] w_pulse;
            assign w_wr[gi]  = w_apply && (w_ch == CH_BITS'(gi));
            assign w_pulse   = 32'(MIN_CYC) + 32'(r_active[gi]) * 32'(STEP_CYC);
            assign w_pwm[gi] = (32'(r_frame_ctr) < w_pulse);
        end
    endgenerate

    // Shared frame counter and the registered frame_start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_ctr   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_ctr   <= w_frame_end ? '0 : r_frame_ctr + FR_W'(1);
            r_frame_start <= (r_frame_ctr == '0);
        end
    end

    // Registered PWM outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_servo_q <= '0;
        end else begin
            r_servo_q <= w_pwm;
        end
    end

    // Shadow positions take table writes; active positions load at frame end,
    // with a same-cycle write bypassing straight into the active set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i] <= CENTRE;
                r_active[i] <= CENTRE;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_wr[i]) begin
                    r_shadow[i] <= w_pos;
                end
                if (w_frame_end) begin
                    r_active[i] <= w_wr[i] ? w_pos : r_shadow[i];
                end
            end
        end
    end

    // Table-walk sequencer with registered address/busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_address   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_dwell_ctr <= '0;
        end else if (stop) begin
            r_state   <= S_IDLE;
            r_address <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_address <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    r_last      <= w_last;
                    r_dwell_ctr <= DW_W'(w_dwell) * MS_CYC_W;
                    r_state     <= S_DWELL;
                end
                S_DWELL: begin
                    if (r_dwell_ctr == '0) begin
                        if (r_last || (r_address == {ADDR_LEN{1'b1}})) begin
`ifdef SERVO_LOOP_EN
                            r_address <= '0;
                            r_state   <= S_FETCH;
`else
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
`endif
                        end else begin
                            r_address <= r_address + ADDR_LEN'(1);
                            r_state   <= S_FETCH;
                        end
                    end else begin
                        r_dwell_ctr <= r_dwell_ctr - DW_W'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_address <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign address     = r_address;
    assign servo_q     = r_servo_q;
    assign busy        = r_busy;
    assign done        = r_done;
    assign frame_start = r_frame_start;

endmodule
